// File: rtl/instruction_block_memory_if.sv
// rtl/instruction_block_memory_if.sv - cache-miss block read and program preload bus
//
// Purpose: groups the instruction-cache miss handshake and the word preload port.
//   master : cache controller / boot logic side (drives requests and loads)
//   slave  : instruction block memory side (returns blocks, reports busy/ready)
// Signals:
//   mem_Read        master->slave  block read request, held until serviced
//   mem_Address     master->slave  block address (PC[31:4])
//   mem_Readdata    slave->master  128-bit block, word k in [32k+31:32k]
//   mem_BusyWait    slave->master  high while a read is in progress
//   load_en         master->slave  word write strobe for preload
//   load_word_addr  master->slave  word index to write
//   load_data       master->slave  word to write
//   load_ready      slave->master  high when a load would be accepted
interface instruction_block_memory_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int LOAD_AW    = 10
);
    logic                  mem_Read;
    logic [ADDR_WIDTH-1:0] mem_Address;
    logic [127:0]          mem_Readdata;
    logic                  mem_BusyWait;
    logic                  load_en;
    logic [LOAD_AW-1:0]    load_word_addr;
    logic [31:0]           load_data;
    logic                  load_ready;

    modport master (
        output mem_Read, mem_Address, load_en, load_word_addr, load_data,
        input  mem_Readdata, mem_BusyWait, load_ready
    );

    modport slave (
        input  mem_Read, mem_Address, load_en, load_word_addr, load_data,
        output mem_Readdata, mem_BusyWait, load_ready
    );
endinterface

// File: rtl/instruction_block_memory.sv
// rtl/instruction_block_memory.sv - instruction-cache miss responder serving 4-word blocks
//
// Purpose: holds the program image in a word array (preloaded over the load port)
//   and answers cache-miss block reads after a fixed latency.
// Ports:
//   clock  input   system clock, all state on rising edge
//   reset  input   asynchronous, active-low reset (word array is not cleared)
//   bus    slave   instruction_block_memory_if (request/response + preload)
module instruction_block_memory #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 4,
    parameter int ADDR_WIDTH   = 28
) (
    input  logic                        clock,
    input  logic                        reset,
    instruction_block_memory_if.slave   bus
);
    localparam int WORD_AW = $clog2(DEPTH_WORDS);
    localparam int IDX_W   = WORD_AW - 2;
    localparam int CNT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [127:0]          rdata_q;
    logic                  busy_q;
    logic                  ready_q;

    logic [31:0]           mem_q [DEPTH_WORDS];

    // Only the low index bits select a block; upper address bits alias.
    logic [IDX_W-1:0]      blk_idx;
    logic [127:0]          blk_data;
    logic                  start_req;
    logic                  load_we;

    assign blk_idx  = addr_q[IDX_W-1:0];
    assign blk_data = {mem_q[{blk_idx, 2'd3}], mem_q[{blk_idx, 2'd2}],
                       mem_q[{blk_idx, 2'd1}], mem_q[{blk_idx, 2'd0}]};

    // In DONE a request for the block already presented is not re-read;
    // any other address starts a fresh read immediately.
    assign start_req = bus.mem_Read &&
                       ((state_q == IDLE) ||
                        ((state_q == DONE) && (bus.mem_Address != addr_q)));

    // A pending read request always wins over a preload in the same cycle.
    assign load_we = bus.load_en && !bus.mem_Read && (state_q != BUSY);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_req) begin
                        addr_q  <= bus.mem_Address;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= BUSY;
                    end else if (!bus.mem_Read) begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        rdata_q <= blk_data;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Program storage carries no reset so a reset never loses the image.
    always_ff @(posedge clock) begin
        if (load_we) begin
            mem_q[bus.load_word_addr] <= bus.load_data;
        end
    end

    assign bus.mem_Readdata = rdata_q;
    assign bus.mem_BusyWait = busy_q;
    assign bus.load_ready   = ready_q;
endmodule

// File: tb/tb_instruction_block_memory.sv
// tb/tb_instruction_block_memory.sv - self-checking bench for instruction_block_memory
module tb_instruction_block_memory;
    localparam int DEPTH = 1024;
    localparam int LAT   = 4;
    localparam int AW    = 28;
    localparam int LAW   = 10;

    localparam logic [127:0] BLK0   = 128'h00000016_00000015_00000014_00000013;
    localparam logic [127:0] BLK1   = 128'h0000001A_00000019_00000018_00000017;
    localparam logic [127:0] BLK1_D = 128'h0000001A_00000019_DEADBEEF_00000017;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    instruction_block_memory_if #(.ADDR_WIDTH(AW), .LOAD_AW(LAW)) ifa ();
    instruction_block_memory_if #(.ADDR_WIDTH(AW), .LOAD_AW(LAW)) ifb ();

    instruction_block_memory #(
        .DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT), .ADDR_WIDTH(AW)
    ) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa)
    );

    instruction_block_memory #(
        .DEPTH_WORDS(DEPTH), .READ_LATENCY(1), .ADDR_WIDTH(AW)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Transaction-level model of dut_a: a read issued at cycle N is due at N+LAT.
    logic [31:0]   mm [DEPTH];
    int            cyc      = 0;
    int            due      = -1;
    logic [AW-1:0] m_addr   = '0;
    bit            m_done   = 1'b0;
    logic [127:0]  exp_data = '0;
    bit            exp_busy = 1'b0;

    function automatic logic [127:0] blk(input logic [AW-1:0] a);
        int b;
        b = int'(a) % (DEPTH / 4);
        return {mm[4*b+3], mm[4*b+2], mm[4*b+1], mm[4*b]};
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            due      = -1;
            m_done   = 1'b0;
            m_addr   = '0;
            exp_data = '0;
            exp_busy = 1'b0;
        end else begin
            cyc++;
            if (due >= 0) begin
                if (cyc == due) begin
                    exp_data = blk(m_addr);
                    exp_busy = 1'b0;
                    due      = -1;
                    m_done   = 1'b1;
                end
            end else if (ifa.mem_Read) begin
                if (!(m_done && ifa.mem_Address == m_addr)) begin
                    m_addr   = ifa.mem_Address;
                    due      = cyc + LAT;
                    exp_busy = 1'b1;
                    m_done   = 1'b0;
                end
            end else begin
                m_done = 1'b0;
                if (ifa.load_en) mm[ifa.load_word_addr] = ifa.load_data;
            end
        end
    end

    always @(negedge clock) begin
        chk("cyc_busy",  ifa.mem_BusyWait, exp_busy);
        chk("cyc_rdata", ifa.mem_Readdata, exp_data);
        chk("cyc_ready", ifa.load_ready,   due < 0);
    end

    initial begin
        reset = 1'b0;
        ifa.mem_Read = 1'b0; ifa.mem_Address = '0; ifa.load_en = 1'b0;
        ifa.load_word_addr = '0; ifa.load_data = '0;
        ifb.mem_Read = 1'b0; ifb.mem_Address = '0; ifb.load_en = 1'b0;
        ifb.load_word_addr = '0; ifb.load_data = '0;
        repeat (2) @(negedge clock);
        chk("rst_busy",  ifa.mem_BusyWait, 0);
        chk("rst_data",  ifa.mem_Readdata, 0);
        chk("rst_ready", ifa.load_ready,   1);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            ifa.load_en = 1'b1; ifa.load_word_addr = LAW'(i); ifa.load_data = 32'h13 + i;
            ifb.load_en = 1'b1; ifb.load_word_addr = LAW'(i); ifb.load_data = 32'h13 + i;
            @(negedge clock);
        end
        ifa.load_en = 1'b0; ifb.load_en = 1'b0;

        // First read of block 0: busy after edges 0..3, data after edge 4.
        ifa.mem_Read = 1'b1; ifa.mem_Address = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("a0_busy",  ifa.mem_BusyWait, 1);
            chk("a0_ready", ifa.load_ready,   0);
            chk("a0_nodata", ifa.mem_Readdata, 0);
        end
        @(negedge clock);
        chk("a0_busy_fall", ifa.mem_BusyWait, 0);
        chk("a0_data",      ifa.mem_Readdata, BLK0);

        // Same address held in DONE: no new read.
        @(negedge clock);
        chk("done_hold", ifa.mem_BusyWait, 0);

        // Back-to-back: new address while DONE; load during BUSY is dropped.
        ifa.mem_Address = AW'(1);
        @(negedge clock);
        chk("b2b_busy", ifa.mem_BusyWait, 1);
        ifa.mem_Read = 1'b0;
        ifa.load_en = 1'b1; ifa.load_word_addr = LAW'(5); ifa.load_data = 32'hDEADBEEF;
        @(negedge clock);
        ifa.load_en = 1'b0;
        chk("b2b_hold", ifa.mem_Readdata, BLK0);
        @(negedge clock);
        @(negedge clock);
        chk("b2b_busy3", ifa.mem_BusyWait, 1);
        chk("b2b_hold3", ifa.mem_Readdata, BLK0);
        @(negedge clock);
        chk("b2b_fall", ifa.mem_BusyWait, 0);
        chk("b2b_data", ifa.mem_Readdata, BLK1);

        // Load accepted with mem_Read low, then re-read block 1.
        ifa.load_en = 1'b1; ifa.load_word_addr = LAW'(5); ifa.load_data = 32'hDEADBEEF;
        @(negedge clock);
        ifa.load_en = 1'b0;
        ifa.mem_Read = 1'b1; ifa.mem_Address = AW'(1);
        repeat (5) @(negedge clock);
        chk("load_fall", ifa.mem_BusyWait, 0);
        chk("load_data", ifa.mem_Readdata, BLK1_D);

        // Aliasing: block 0 then 0x101 back-to-back, 0x101 must alias block 1.
        ifa.mem_Address = AW'(0);
        repeat (5) @(negedge clock);
        chk("alias_pre", ifa.mem_Readdata, BLK0);
        ifa.mem_Address = 28'h0000101;
        repeat (5) @(negedge clock);
        chk("alias_fall", ifa.mem_BusyWait, 0);
        chk("alias_data", ifa.mem_Readdata, BLK1_D);

        // Reset two cycles into a read aborts it without a clock edge.
        ifa.mem_Read = 1'b0;
        @(negedge clock);
        ifa.mem_Read = 1'b1; ifa.mem_Address = AW'(1);
        @(negedge clock);
        @(negedge clock);
        #2;
        reset = 1'b0;
        ifa.mem_Read = 1'b0;
        #1;
        chk("abort_busy",  ifa.mem_BusyWait, 0);
        chk("abort_data",  ifa.mem_Readdata, 0);
        chk("abort_ready", ifa.load_ready,   1);
        @(negedge clock);
        reset = 1'b1;
        ifa.mem_Read = 1'b1; ifa.mem_Address = AW'(0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("rerd_busy", ifa.mem_BusyWait, 1);
        end
        @(negedge clock);
        chk("rerd_fall", ifa.mem_BusyWait, 0);
        chk("rerd_data", ifa.mem_Readdata, BLK0);
        ifa.mem_Read = 1'b0;

        // Latency-1 build: busy for exactly one cycle.
        ifb.mem_Read = 1'b1; ifb.mem_Address = AW'(0);
        @(negedge clock);
        chk("lat1_busy",   ifb.mem_BusyWait, 1);
        chk("lat1_nodata", ifb.mem_Readdata, 0);
        @(negedge clock);
        chk("lat1_fall", ifb.mem_BusyWait, 0);
        chk("lat1_data", ifb.mem_Readdata, BLK0);
        ifb.mem_Read = 1'b0;
        repeat (2) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
